// File: rtl/prescaled_counter_if.sv
// prescaled_counter_if: control and status bundle between a timing master and the prescaled counter
interface prescaled_counter_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 16
);
    logic                  en;
    logic [PRESCALE_W-1:0] prescale;
    logic                  dir;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic [WIDTH-1:0]      modulus;
    logic [WIDTH-1:0]      cmp;
    logic [WIDTH-1:0]      count;
    logic                  tick;
    logic                  tc;
    logic                  cmp_out;

    modport master (
        output en, prescale, dir, load, load_val, modulus, cmp,
        input  count, tick, tc, cmp_out
    );

    modport slave (
        input  en, prescale, dir, load, load_val, modulus, cmp,
        output count, tick, tc, cmp_out
    );
endinterface

// File: rtl/prescaled_counter.sv
// prescaled_counter: programmable-modulus up/down counter advanced by a programmable prescaler
module prescaled_counter #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 16
) (
    input logic                clk,
    input logic                rst_n,
    prescaled_counter_if.slave bus
);
    localparam logic [WIDTH-1:0]      CNT_ONE = 1;
    localparam logic [PRESCALE_W-1:0] PS_ONE  = 1;

    logic [PRESCALE_W-1:0] pcnt;
    logic [WIDTH-1:0]      count;
    logic [WIDTH-1:0]      next_count;
    logic                  tick;
    logic                  tc;
    logic                  advance;
    logic                  wrap;

    // advance when the prescaler period is complete; >= also catches a prescale lowered mid-period
    always_comb begin
        advance    = bus.en && (pcnt >= bus.prescale);
        wrap       = bus.dir ? (count >= bus.modulus) : (count == '0);
        next_count = bus.dir ? (wrap ? '0 : count + CNT_ONE)
                             : (wrap ? bus.modulus : count - CNT_ONE);
    end

    // load beats enable; tick and tc are strobes aligned with the new count value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt  <= '0;
            count <= '0;
            tick  <= 1'b0;
            tc    <= 1'b0;
        end else if (bus.load) begin
            pcnt  <= '0;
            count <= bus.load_val;
            tick  <= 1'b0;
            tc    <= 1'b0;
        end else if (advance) begin
            pcnt  <= '0;
            count <= next_count;
            tick  <= 1'b1;
            tc    <= wrap;
        end else begin
            pcnt  <= bus.en ? pcnt + PS_ONE : pcnt;
            tick  <= 1'b0;
            tc    <= 1'b0;
        end
    end

    assign bus.count   = count;
    assign bus.tick    = tick;
    assign bus.tc      = tc;
    assign bus.cmp_out = count < bus.cmp;
endmodule

// File: tb/tb_prescaled_counter.sv
// tb_prescaled_counter: vector table, corner-case sequences and randomized run against a reference model
module tb_prescaled_counter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    int   m_count;
    int   m_phase;
    int   m_tick;
    int   m_tc;

    prescaled_counter_if #(.WIDTH(8), .PRESCALE_W(16)) bus ();

    prescaled_counter #(.WIDTH(8), .PRESCALE_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ld;
        logic        en;
        logic        dir;
        logic [15:0] ps;
        logic [7:0]  lv;
        logic [7:0]  md;
        logic [7:0]  cp;
        int          e_cnt;
        int          e_tick;
        int          e_tc;
        int          e_cmp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic ld, logic en, logic dir, int ps, int lv, int md, int cp,
                                int cnt, int tk, int tcv, int co);
        vec_t v;
        v.ld = ld; v.en = en; v.dir = dir; v.ps = 16'(ps); v.lv = 8'(lv); v.md = 8'(md); v.cp = 8'(cp);
        v.e_cnt = cnt; v.e_tick = tk; v.e_tc = tcv; v.e_cmp = co;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_phase = 0; m_tick = 0; m_tc = 0;
    endtask

    // counter behaviour stated as phase counting and modular arithmetic
    task automatic model_edge();
        if (!rst_n) model_reset();
        else if (bus.load) begin
            m_count = int'(bus.load_val); m_phase = 0; m_tick = 0; m_tc = 0;
        end else if (!bus.en) begin
            m_tick = 0; m_tc = 0;
        end else if (m_phase < int'(bus.prescale)) begin
            m_phase++; m_tick = 0; m_tc = 0;
        end else begin
            m_phase = 0; m_tick = 1;
            if (bus.dir) begin
                m_tc = (m_count >= int'(bus.modulus)) ? 1 : 0;
                m_count = m_tc ? 0 : (m_count + 1) % 256;
            end else begin
                m_tc = (m_count == 0) ? 1 : 0;
                m_count = m_tc ? int'(bus.modulus) : m_count - 1;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check("count", int'(bus.count), m_count);
        check("tick", int'(bus.tick), m_tick);
        check("tc", int'(bus.tc), m_tc);
        check("cmp_out", int'(bus.cmp_out), (m_count < int'(bus.cmp)) ? 1 : 0);
    endtask

    task automatic drive(input logic ld, input logic en, input logic dir, input int ps,
                         input int lv, input int md, input int cp);
        bus.load = ld; bus.en = en; bus.dir = dir; bus.prescale = 16'(ps);
        bus.load_val = 8'(lv); bus.modulus = 8'(md); bus.cmp = 8'(cp);
    endtask

    initial begin
        int n;
        int highs;
        model_reset();
        drive(0, 1, 1, 0, 0, 9, 3);

        // table: basic up count, down wrap after load, out-of-range loads, cmp=0
        for (int i = 0; i < 12; i++)
            vecs.push_back(mk(0, 1, 1, 0, 0, 9, 3, (i + 1) % 10, 1, ((i + 1) % 10 == 0) ? 1 : 0,
                              ((i + 1) % 10 < 3) ? 1 : 0));
        vecs.push_back(mk(1, 1, 0, 0, 2, 9, 3, 2, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 3, 1, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 3, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 3, 9, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 3, 8, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 200, 5, 3, 200, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 5, 3, 0, 1, 1, 1));
        vecs.push_back(mk(1, 1, 0, 0, 200, 5, 3, 200, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 5, 3, 199, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 5, 3, 198, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 5, 0, 197, 1, 0, 0));

        // reset state
        #1;
        check("rst_count", int'(bus.count), 0);
        check("rst_tick", int'(bus.tick), 0);
        check("rst_tc", int'(bus.tc), 0);
        check("rst_cmp_out", int'(bus.cmp_out), 1);
        cyc();
        cyc();
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].en, vecs[i].dir, int'(vecs[i].ps), int'(vecs[i].lv),
                  int'(vecs[i].md), int'(vecs[i].cp));
            cyc();
            check($sformatf("vec%0d_count", i), int'(bus.count), vecs[i].e_cnt);
            check($sformatf("vec%0d_tick", i), int'(bus.tick), vecs[i].e_tick);
            check($sformatf("vec%0d_tc", i), int'(bus.tc), vecs[i].e_tc);
            check($sformatf("vec%0d_cmp", i), int'(bus.cmp_out), vecs[i].e_cmp);
        end

        // prescale=3: tick period 4, then a 2-cycle enable gap stretches it to 6
        drive(1, 1, 1, 3, 0, 255, 3);
        cyc();
        drive(0, 1, 1, 3, 0, 255, 3);
        n = 0;
        do begin cyc(); n++; end while (!bus.tick && n < 20);
        check("ps3_first_period", n, 4);
        n = 0;
        do begin cyc(); n++; end while (!bus.tick && n < 20);
        check("ps3_period", n, 4);
        cyc();
        bus.en = 1'b0;
        cyc();
        cyc();
        bus.en = 1'b1;
        n = 3;
        do begin cyc(); n++; end while (!bus.tick && n < 20);
        check("ps3_stretched_period", n, 6);

        // load during an advancing edge wins; prescaler restarts from zero
        drive(0, 1, 1, 0, 0, 255, 3);
        cyc();
        drive(1, 1, 1, 0, 42, 255, 3);
        cyc();
        check("load_over_adv_count", int'(bus.count), 42);
        check("load_over_adv_tick", int'(bus.tick), 0);
        drive(0, 1, 1, 2, 0, 255, 3);
        n = 0;
        do begin cyc(); n++; end while (!bus.tick && n < 20);
        check("after_load_period", n, 3);

        // prescale lowered mid-period: advance on the next enabled edge
        drive(0, 1, 1, 10, 0, 255, 3);
        repeat (5) cyc();
        bus.prescale = 16'd2;
        cyc();
        check("ps_lowered_tick", int'(bus.tick), 1);

        // full-range up wrap 255 -> 0
        drive(1, 1, 1, 0, 254, 255, 3);
        cyc();
        bus.load = 1'b0;
        cyc();
        check("wrap255_count", int'(bus.count), 255);
        cyc();
        check("wrap255_tc", int'(bus.tc), 1);
        check("wrap255_zero", int'(bus.count), 0);

        // modulus=0 holds at 0 with tc on every advance in both directions
        drive(1, 1, 1, 0, 0, 0, 3);
        cyc();
        bus.load = 1'b0;
        repeat (3) begin
            cyc();
            check("mod0_up_tc", int'(bus.tc), 1);
        end
        bus.dir = 1'b0;
        repeat (3) begin
            cyc();
            check("mod0_dn_count", int'(bus.count), 0);
        end

        // PWM duty: cmp=3 over modulus 9 gives 3 highs in 10, cmp=0 gives none
        drive(1, 1, 1, 0, 0, 9, 3);
        cyc();
        bus.load = 1'b0;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            highs += int'(bus.cmp_out);
        end
        check("duty_cmp3", highs, 3);
        bus.cmp = 8'd0;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            highs += int'(bus.cmp_out);
        end
        check("duty_cmp0", highs, 0);

        // async reset between edges with count=7, pcnt=2
        drive(1, 1, 1, 3, 6, 255, 3);
        cyc();
        bus.load = 1'b0;
        repeat (6) cyc();
        check("pre_rst_count", int'(bus.count), 7);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_count", int'(bus.count), 0);
        check("async_rst_tick", int'(bus.tick), 0);
        check("async_rst_tc", int'(bus.tc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!bus.tick && n < 20);
        check("post_rst_first_adv", n, 4);

        // randomized run
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0), 1'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 20)),
                  ($urandom_range(0, 9) == 0) ? 255 : int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 16)));
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prescaled_counter.md
Name: prescaled_counter

Overview:
- Parametrised successor to the free-running LED counter: one programmable-modulus up/down counter behind a programmable prescaler.
- Adds synchronous load, enable, terminal-count and prescaler-tick strobes, and a compare output usable as a PWM / blink-rate signal.
- Sits directly behind the PLL output clock and drives LEDs or timing strobes to neighbouring blocks.

Parameters:
WIDTH, 8, width of count, load_val, modulus, cmp
PRESCALE_W, 16, width of prescale and of the internal prescaler counter

Ports:
clk  input  1  system clock (PLL output); all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  count enable; low freezes prescaler and counter
prescale  input  PRESCALE_W  tick period minus one (counter advances every prescale+1 enabled cycles)
dir  input  1  1 = count up, 0 = count down
load  input  1  synchronous load strobe
load_val  input  WIDTH  value written to count on load
modulus  input  WIDTH  top value; count range 0..modulus
cmp  input  WIDTH  compare threshold
count  output  WIDTH  current count (registered)
tick  output  1  one-cycle strobe, high in the cycle after each count advance
tc  output  1  one-cycle strobe, high in the cycle after a wrap
cmp_out  output  1  (count < cmp), combinational from registered count

Behaviour:
- Reset: asserted rst_n=0 immediately forces count=0, internal pcnt=0, tick=0, tc=0. cmp_out = (0 < cmp), i.e. 1 when cmp != 0. Release is synchronous-safe; first advance may occur no earlier than prescale+1 enabled cycles after release.
- Priority per edge: load > en > hold.
- load=1 (en ignored):
  - count <= load_val; pcnt <= 0; tick <= 0; tc <= 0.
  - Values above modulus are accepted.
- en=0, load=0: count and pcnt hold; tick <= 0; tc <= 0.
- en=1, load=0, pcnt != prescale: pcnt <= pcnt+1; count holds; tick <= 0; tc <= 0.
- en=1, load=0, pcnt == prescale (advance): pcnt <= 0; tick <= 1.
  - Up: if count >= modulus then count <= 0, tc <= 1; else count <= count+1, tc <= 0.
  - Down: if count == 0 then count <= modulus, tc <= 1; else count <= count-1, tc <= 0. A count above modulus decrements normally.
- prescale=0: advance on every enabled cycle; tick stays high continuously while en=1.
- pcnt > prescale (prescale lowered mid-period): treated as pcnt == prescale, i.e. advance on the next enabled edge. Compare as pcnt >= prescale.
- modulus=0: up and down both hold count at 0; tc and tick high on every advance.
- dir, modulus and cmp may change at any cycle. The value sampled at the advancing edge governs that advance.
- tick and tc are registered: they are high in the same cycle as the new count value.
- All arithmetic is unsigned and modulo 2^WIDTH. With modulus = 2^WIDTH-1, up-wrap 255->0 asserts tc.
- No latency on cmp_out beyond count itself.

Test Plan:
- Reset/basic up: WIDTH=8, prescale=0, modulus=9, dir=1, en=1 for 12 cycles after reset release -> count 1,2..9,0,1,2; tc=1 only in the cycle count shows 0; tick=1 every cycle.
- Prescale: prescale=3, modulus=255, en=1 -> count advances every 4th cycle, tick high one cycle in four aligned with each new value. Drop en for 2 cycles mid-period -> period stretches by exactly 2.
- Down wrap and load: load=1, load_val=2, then dir=0, prescale=0 -> count 2,1,0,modulus(9),8; tc high with the 9. Load asserted together with en during an advance -> count=load_val, tick=0, tc=0, pcnt restarts.
- Out-of-range load: modulus=5, load_val=200, dir=1 -> next advance gives count=0 with tc=1. Same load with dir=0 -> 199,198,...
- Compare/PWM: modulus=9, cmp=3, prescale=0, up -> cmp_out high for counts 0,1,2 and low for 3..9, giving a 30% duty over a 10-cycle period. cmp=0 -> cmp_out always 0.
- Async reset mid-run: pull rst_n low between edges with count=7, pcnt=2 -> count=0, tick=0, tc=0 before the next edge. After release, first advance comes after prescale+1 enabled cycles.
